// File: rtl/count_disp_pkg.sv
// Shared types, 7-segment patterns and helpers for the BCD display slice.
`timescale 1ns/1ps
package count_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Segment order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [6:0] seg7_of(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Decimal digits needed to hold the largest WIDTH-bit value.
   function automatic int digits_needed(input int width);
      longint unsigned v;
      int n;
      v = (64'd1 << width) - 64'd1;
      n = 1;
      while (v >= 64'd10) begin
         v = v / 64'd10;
         n = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per clock, WIDTH steps per value.
// Handshake: a value transfers on a rising edge where in_valid && ready; in_valid while busy is dropped.
`timescale 1ns/1ps
module bin2bcd_serial
   import count_disp_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_value,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  bcd_valid,
   output state_t                state
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]       cnt;
   logic [WIDTH-1:0]    bin_q;
   logic [4*DIGITS-1:0] acc_q;
   logic [4*DIGITS-1:0] acc_adj;
   logic                ready;

   assign ready = (state == IDLE);

   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         bcd_out   <= '0;
         bcd_valid <= 1'b0;
         cnt       <= '0;
         bin_q     <= '0;
         acc_q     <= '0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && ready) begin
                  bin_q <= in_value;
                  acc_q <= '0;
                  cnt   <= CW'(WIDTH);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               bcd_out   <= acc_q;
               bcd_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/count_bcd_display.sv
// Binary count to packed BCD plus a time-multiplexed 7-segment driver with leading-zero blanking.
`timescale 1ns/1ps
module count_bcd_display
   import count_disp_pkg::*;
#(
   parameter int WIDTH    = 10,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1024,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_value,
   output logic                  bcd_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_en
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (digits_needed(WIDTH) > DIGITS) begin : g_width_check
      $error("count_bcd_display: DIGITS too small for WIDTH");
   end

   state_t        conv_state;
   logic [PW-1:0] presc;
   logic [IW-1:0] idx;
   logic          wrap;
   logic [3:0]    nib;
   logic          lz_run;
   logic          blank;

   bin2bcd_serial #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_value  (in_value),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid),
      .state     (conv_state)
   );

   assign in_ready = (conv_state == IDLE);
   assign wrap     = (presc == PW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc  <= '0;
         idx    <= '0;
         dig_en <= DIGITS'(1);
      end else begin
         presc <= wrap ? '0 : presc + PW'(1);
         if (wrap) begin
            if (idx == IW'(DIGITS - 1)) begin
               idx    <= '0;
               dig_en <= DIGITS'(1);
            end else begin
               idx    <= idx + IW'(1);
               dig_en <= dig_en << 1;
            end
         end
      end
   end

   // Decode straight from bcd_out so a result landing on a scan wrap is shown at once.
   always_comb begin
      nib    = '0;
      lz_run = 1'b1;
      blank  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) nib = bcd_out[4*i +: 4];
      end
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lz_run = lz_run && (bcd_out[4*i +: 4] == 4'd0);
         if (idx == IW'(i)) blank = lz_run;
      end
      seg = ((BLANK_LZ != 0) && blank) ? SEG_BLANK : seg7_of(nib);
   end

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display: conversion latency, scan/blanking, streaming, reset abort.
`timescale 1ns/1ps
module tb_count_bcd_display;

   localparam int W  = 10;
   localparam int D  = 4;
   localparam int SD = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic [W-1:0]   in_value = '0;
   logic           in_ready, bcd_valid;
   logic [4*D-1:0] bcd_out;
   logic [6:0]     seg;
   logic [D-1:0]   dig_en;

   logic           nb_ready, nb_valid;
   logic [4*D-1:0] nb_bcd;
   logic [6:0]     nb_seg;
   logic [D-1:0]   nb_dig;

   int             total = 0;
   int             bad = 0;
   int             valid_cnt = 0;
   logic [4*D-1:0] exp_q[$];
   logic [4*D-1:0] mon_exp;
   int             stim_q[$];
   logic [6:0]     seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   count_bcd_display #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD), .BLANK_LZ(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
      .bcd_valid(bcd_valid), .bcd_out(bcd_out), .seg(seg), .dig_en(dig_en)
   );

   count_bcd_display #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD), .BLANK_LZ(0)) u_dut_nb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_ready), .in_value(in_value),
      .bcd_valid(nb_valid), .bcd_out(nb_bcd), .seg(nb_seg), .dig_en(nb_dig)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish, required finish within 5ms");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // scoreboard: push on accept, pop on bcd_valid
   always @(negedge clk) begin
      if (rst && in_valid && in_ready) exp_q.push_back(ref_bcd(int'(in_value)));
      if (bcd_valid) begin
         valid_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL bcd_unexpected: got %h, required no output", bcd_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bcd_out !== mon_exp) begin
               bad++;
               $display("FAIL bcd_out: got %h, required %h", bcd_out, mon_exp);
            end
         end
      end
   end

   task automatic wait_drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || !in_ready) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (exp_q.size() != 0 || !in_ready) begin
         bad++;
         $display("FAIL drain: got %0d pending, required 0 within 200 clks", exp_q.size());
      end
   endtask

   // drives stim_q with in_valid held high, moving to the next value on each accept
   task automatic run_stream(input bit check_gap);
      int  n, cyc, last, cnt, v0;
      bit  acc;
      n = 0; cyc = 0; last = 0;
      cnt = stim_q.size();
      v0 = valid_cnt;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_value = W'(stim_q[0]);
      while (n < cnt && cyc < cnt * 14 + 50) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            if (check_gap && n > 0) begin
               total++;
               if (cyc - last != 12) begin
                  bad++;
                  $display("FAIL accept_gap: got %0d clks, required 12", cyc - last);
               end
            end
            last = cyc;
            n++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            if (n == cnt) in_valid = 1'b0;
            else in_value = W'(stim_q[n]);
         end
      end
      in_valid = 1'b0;
      total++;
      if (n != cnt) begin
         bad++;
         $display("FAIL stream_accepts: got %0d, required %0d", n, cnt);
      end
      stim_q.delete();
      wait_drain();
      total++;
      if (valid_cnt - v0 != n) begin
         bad++;
         $display("FAIL valid_count: got %0d, required %0d", valid_cnt - v0, n);
      end
   endtask

   task automatic do_convert(input int v);
      stim_q.push_back(v);
      run_stream(1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      total += 5;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", in_ready); end
      if (bcd_out !== 16'h0000) begin bad++; $display("FAIL rst_bcd: got %h, required 0000", bcd_out); end
      if (dig_en !== 4'b0001) begin bad++; $display("FAIL rst_dig_en: got %b, required 0001", dig_en); end
      if (seg !== 7'h3F) begin bad++; $display("FAIL rst_seg: got %h, required 3f", seg); end
      if (bcd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", bcd_valid); end
   endtask

   task automatic test_latency();
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_value = W'(1023);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_value = W'(5);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         total += 2;
         if (in_ready !== (k >= 11)) begin
            bad++;
            $display("FAIL lat_ready edge %0d: got %b, required %b", k, in_ready, (k >= 11));
         end
         if (bcd_valid !== (k == 11)) begin
            bad++;
            $display("FAIL lat_valid edge %0d: got %b, required %b", k, bcd_valid, (k == 11));
         end
         if (k == 11) begin
            total++;
            if (bcd_out !== 16'h1023) begin
               bad++;
               $display("FAIL lat_bcd: got %h, required 1023", bcd_out);
            end
         end
      end
   endtask

   task automatic test_scan(input int v);
      logic [D-1:0] prev;
      int           k, dv, di;
      logic [6:0]   e_seg, e_nb;
      do_convert(v);
      prev = dig_en;
      k = 0;
      @(posedge clk); #1;
      while (!(dig_en == 4'b0001 && prev != 4'b0001) && k < 50) begin
         prev = dig_en;
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (k >= 50) begin
         bad++;
         $display("FAIL scan_align: got no wrap to 0001, required one within 50 clks");
      end
      for (int c = 0; c <= 16; c++) begin
         di = (c / SD) % D;
         dv = v;
         for (int j = 0; j < di; j++) dv = dv / 10;
         e_nb  = seg_tab[dv % 10];
         e_seg = (di > 0 && dv == 0) ? 7'h00 : e_nb;
         total += 3;
         if (dig_en !== 4'(1 << di)) begin
            bad++;
            $display("FAIL scan_dig_en v=%0d c=%0d: got %b, required %b", v, c, dig_en, 4'(1 << di));
         end
         if (seg !== e_seg) begin
            bad++;
            $display("FAIL scan_seg v=%0d digit=%0d: got %h, required %h", v, di, seg, e_seg);
         end
         if (nb_seg !== e_nb) begin
            bad++;
            $display("FAIL scan_seg_noblank v=%0d digit=%0d: got %h, required %h", v, di, nb_seg, e_nb);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_q = '{0, 500, 999};
      run_stream(1'b1);
      total++;
      if (bcd_out !== 16'h0999) begin
         bad++;
         $display("FAIL b2b_last: got %h, required 0999", bcd_out);
      end
   endtask

   task automatic test_reset_abort();
      int v0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_value = W'(777);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      v0 = valid_cnt;
      @(posedge clk); #1;
      rst = 1'b1;
      total += 2;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b, required 1", in_ready); end
      if (bcd_out !== 16'h0000) begin bad++; $display("FAIL abort_bcd: got %h, required 0000", bcd_out); end
      repeat (20) @(posedge clk);
      #1;
      total += 2;
      if (valid_cnt != v0) begin bad++; $display("FAIL abort_valid: got %0d pulses, required 0", valid_cnt - v0); end
      if (bcd_out !== 16'h0000) begin bad++; $display("FAIL abort_hold: got %h, required 0000", bcd_out); end
      do_convert(42);
      total++;
      if (bcd_out !== 16'h0042) begin bad++; $display("FAIL abort_next: got %h, required 0042", bcd_out); end
   endtask

   task automatic test_exhaustive();
      for (int v = 0; v < 1024; v++) stim_q.push_back(v);
      run_stream(1'b1);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_scan(9);
      test_scan(1000);
      test_back_to_back();
      test_reset_abort();
      test_exhaustive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
